serial_parity_rx: RTL and testbench
===================================

# serial_parity_rx

Serial receiver and checker for parity-protected words: collects `DATA_W` data bits LSB-first, then one parity bit. It recomputes XNOR-reduction parity over the data and flags a mismatch. It is the receive end of the team's XNOR-parity link: the transmit side serialises a word followed by `~^data`. Sits between the serial pin sampler and word-level consumers.

## Interface
- `DATA_W`, default 8: data bits per frame; legal 2..32.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  `in_bit` (and `in_start`) sampled this cycle.
- `in_bit`  input  1  serial bit.
- `in_start`  input  1  marks the first data bit of a frame; ignored unless `in_valid`=1.
- `out_valid`  output  1  one-cycle pulse: frame complete.
- `out_data`  output  `DATA_W`  received word; held until the next `out_valid`.
- `out_par_err`  output  1  parity mismatch of the completed frame; qualified by `out_valid`, held with `out_data`.
- `out_frm_err`  output  1  one-cycle pulse: a frame was aborted by an early `in_start`.
- `busy`  output  1  high while in `DATA` or `PARITY`.

## Operation
- FSM states `IDLE`, `DATA`, `PARITY`. Bit counter is `clog2(DATA_W)` wide.
- **`IDLE`**
  - `in_valid & in_start`: shift `in_bit` into bit 0, set counter=1, seed the running parity accumulator with `in_bit`, go to `DATA`.
  - `in_valid` without `in_start`: bit discarded.
- **`DATA`**
  - Each `in_valid` bit lands at position `counter`; the accumulator XORs in the bit; counter increments.
  - When counter reaches `DATA_W`, go to `PARITY`.
- **`PARITY`**
  - Next `in_valid` bit is the parity bit.
  - Expected parity = `~(accumulator)`, i.e. `~^data`. `out_par_err` = `(in_bit != expected)`.
  - Commit the word to `out_data`, pulse `out_valid`, go to `IDLE`.
- **Early start**: `in_valid & in_start` while in `DATA` or `PARITY`:
  - Pulse `out_frm_err`.
  - Discard the partial frame; `out_data` and `out_par_err` keep their prior values.
  - Restart with this bit as bit 0 and stay in or enter `DATA`.
- **`in_start` in `PARITY`**: always an abort; it is never treated as a parity bit.
- **Gaps**: `in_valid`=0 cycles are gaps with no state change and unlimited length.
- **`DATA_W`=2**: `DATA` lasts exactly one more valid bit after the start bit.

## Timing
- Reset values (the cycle after `rst_n` is sampled low):
  - state=`IDLE`, counter=0, accumulator=0.
  - `out_valid`=0, `out_data`=0, `out_par_err`=0, `out_frm_err`=0, `busy`=0.
- **Reset mid-frame**: the partial frame is dropped; no `out_valid` or `out_frm_err` pulse.
- **Output latency**: all outputs are registered. `out_valid` rises in the cycle after the edge that samples the parity bit, and stays high for exactly 1 cycle.
- **Back-to-back frames**: the cycle that `out_valid` is high may also accept `in_valid & in_start` for the next frame. Zero bubble is required, so a frame takes `DATA_W`+1 valid cycles.
- **`busy` timing**: asserts the cycle after the start bit is accepted. It deasserts in the same cycle `out_valid` asserts.
- **`out_frm_err`**: asserts the cycle after the aborting start bit, for 1 cycle.

## Configuration
- `PARITY_RX_ERR_CNT_EN` defined:
  - Adds output `err_cnt` [7:0] and input `err_cnt_clr`.
  - `err_cnt` increments on each `out_valid` with `out_par_err`=1 and on each `out_frm_err` pulse.
  - Saturates at 255. Reset value 0.
  - `err_cnt_clr`=1 forces 0 next cycle and wins over a simultaneous increment.
- Not defined: ports `err_cnt` and `err_cnt_clr` are absent and no counter logic exists; all other behaviour is identical.

## Test plan
- `DATA_W`=8, continuous `in_valid`, start + bits of 0xA5 LSB-first, parity bit 1 -> `out_valid` pulse 1 cycle after parity, `out_data`=0xA5, `out_par_err`=0.
- Same frame with parity bit 0 -> `out_data`=0xA5, `out_par_err`=1. With the macro defined, `err_cnt`=1.
- 0x3C with parity 1, random `in_valid` gaps of 0–5 cycles -> identical result to the gapless case; `busy` stays high through the gaps.
- Start, 4 bits, then `in_start` again followed by 0xFF with parity 1 -> `out_frm_err` pulse; then `out_data`=0xFF, `out_par_err`=0.
- Two frames back-to-back (0x01 parity 0, 0x80 parity 0) -> two `out_valid` pulses exactly 9 cycles apart, both with `out_par_err`=0.
- `rst_n` low for 1 cycle at bit 5 of a frame -> all outputs at reset values. A subsequent clean 0x5A frame with parity 1 is received correctly.

Source files
------------

// File: rtl/serial_parity_rx.sv
// Serial receiver for XNOR-parity frames: DATA_W data bits LSB-first, then ~^data.
// Optional error counter (err_cnt / err_cnt_clr) is enabled by defining PARITY_RX_ERR_CNT_EN.
module serial_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_start,
`ifdef PARITY_RX_ERR_CNT_EN
  input  logic              err_cnt_clr,
  output logic [7:0]        err_cnt,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frm_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_par_err_q, out_par_err_d;
  logic              out_frm_err_q, out_frm_err_d;

  // A start bit always (re)opens a frame; in DATA/PARITY it also aborts the partial one.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    shreg_d       = shreg_q;
    out_valid_d   = 1'b0;
    out_frm_err_d = 1'b0;
    out_data_d    = out_data_q;
    out_par_err_d = out_par_err_q;
    if (in_valid) begin
      if (in_start) begin
        out_frm_err_d = (state_q != IDLE);
        shreg_d       = '0;
        shreg_d[0]    = in_bit;
        cnt_d         = CNT_W'(1);
        acc_d         = in_bit;
        state_d       = DATA;
      end else begin
        case (state_q)
          DATA: begin
            shreg_d[cnt_q] = in_bit;
            acc_d          = acc_q ^ in_bit;
            if (cnt_q == LAST_IDX) begin
              cnt_d   = '0;
              state_d = PARITY;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PARITY: begin
            out_valid_d   = 1'b1;
            out_data_d    = shreg_q;
            out_par_err_d = (in_bit != ~acc_q);
            cnt_d         = '0;
            acc_d         = 1'b0;
            state_d       = IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      shreg_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_par_err_q <= 1'b0;
      out_frm_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      shreg_q       <= shreg_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_par_err_q <= out_par_err_d;
      out_frm_err_q <= out_frm_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_par_err = out_par_err_q;
  assign out_frm_err = out_frm_err_q;
  assign busy        = (state_q != IDLE);

`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts in step with the error pulses; clear beats a simultaneous increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (((out_valid_d && out_par_err_d) || out_frm_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: vector table, hand-written corner sequences,
// and randomized frames against a parity reference model.
module tb_serial_parity_rx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_bit;
  logic              in_start;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_par_err;
  logic              out_frm_err;
  logic              busy;
`ifdef PARITY_RX_ERR_CNT_EN
  logic              err_cnt_clr;
  logic [7:0]        err_cnt;
`endif

  serial_parity_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_start   (in_start),
`ifdef PARITY_RX_ERR_CNT_EN
    .err_cnt_clr(err_cnt_clr),
    .err_cnt    (err_cnt),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_par_err(out_par_err),
    .out_frm_err(out_frm_err),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       busy;
    int         cyc;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_drive_cyc = 0;
  int   frm_pulses = 0;
  int   exp_frm_pulses = 0;
  int   model_err = 0;
  logic [7:0] last_data = '0;
  logic       last_err = 1'b0;
  res_t resq[$];
  vec_t vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every completed frame and abort pulse as seen on the outputs.
  always @(negedge clk) begin
    if (rst_n && out_valid) resq.push_back('{out_data, out_par_err, busy, cyc});
    if (rst_n && out_frm_err) frm_pulses++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: transmitter sends 1 when the data has an even number of ones.
  function automatic logic refErr(input logic [7:0] d, input logic p);
    int ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    return p != ((ones % 2) == 0);
  endfunction

  task automatic applyStimulus(input logic b, input logic s, input int maxgap, input bit chkBusy);
    int g;
    g = int'($urandom_range(maxgap, 0));
    for (int i = 0; i < g; i++) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      in_start = 1'($urandom);
      tick();
      if (chkBusy) checkOutput("busy_gap", {31'b0, busy}, 32'd1);
    end
    in_valid = 1'b1;
    in_bit   = b;
    in_start = s;
    last_drive_cyc = cyc;
    tick();
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input int maxgap);
    applyStimulus(d[0], 1'b1, maxgap, 1'b0);
    for (int i = 1; i < DATA_W; i++) applyStimulus(d[i], 1'b0, maxgap, 1'b1);
    applyStimulus(p, 1'b0, maxgap, 1'b1);
  endtask

  task automatic getResult(output res_t r, output bit ok);
    int k = 0;
    while (resq.size() == 0 && k < 20) begin
      tick();
      k++;
    end
    if (resq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL out_valid_timeout: got no pulse expected one within 20 cycles");
      r  = '{8'h00, 1'b0, 1'b0, 0};
      ok = 1'b0;
    end else begin
      r  = resq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic expectFrame(input string name, input logic [7:0] d, input logic e);
    res_t r;
    bit   ok;
    getResult(r, ok);
    if (ok) begin
      checkOutput({name, "_data"}, {24'b0, r.data}, {24'b0, d});
      checkOutput({name, "_par_err"}, {31'b0, r.err}, {31'b0, e});
      checkOutput({name, "_busy_low"}, {31'b0, r.busy}, 32'd0);
      checkOutput({name, "_latency"}, r.cyc, last_drive_cyc + 1);
    end
    last_data = d;
    last_err  = e;
    if (e) model_err++;
    tick();
    checkOutput({name, "_valid_width"}, {31'b0, out_valid}, 32'd0);
  endtask

  // Start + nbits junk bits, then an aborting start that begins frame d.
  task automatic runAbort(input string name, input int nbits, input logic [7:0] d, input logic p);
    applyStimulus(1'($urandom), 1'b1, 0, 1'b0);
    for (int i = 0; i < nbits; i++) applyStimulus(1'($urandom), 1'b0, 0, 1'b1);
    applyStimulus(d[0], 1'b1, 0, 1'b0);
    exp_frm_pulses++;
    model_err++;
    checkOutput({name, "_frm_err"}, {31'b0, out_frm_err}, 32'd1);
    checkOutput({name, "_held_data"}, {24'b0, out_data}, {24'b0, last_data});
    checkOutput({name, "_held_err"}, {31'b0, out_par_err}, {31'b0, last_err});
    checkOutput({name, "_no_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd1);
    applyStimulus(d[1], 1'b0, 0, 1'b1);
    checkOutput({name, "_frm_width"}, {31'b0, out_frm_err}, 32'd0);
    for (int i = 2; i < DATA_W; i++) applyStimulus(d[i], 1'b0, 0, 1'b1);
    applyStimulus(p, 1'b0, 0, 1'b1);
    expectFrame(name, d, refErr(d, p));
  endtask

  initial begin
    res_t r1;
    res_t r2;
    bit   ok1;
    bit   ok2;
    logic [7:0] rd;
    logic       rp;
    int         rg;

    vecs[0] = '{8'hA5, 1'b1, 0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 0, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 5, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 2, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 3, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 0, 1'b1};
    vecs[8] = '{8'hFF, 1'b0, 4, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_start = 1'b0;
`ifdef PARITY_RX_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    repeat (3) tick();
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_data", {24'b0, out_data}, 32'd0);
    checkOutput("rst_par_err", {31'b0, out_par_err}, 32'd0);
    checkOutput("rst_frm_err", {31'b0, out_frm_err}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Stray valid bits without a start must be ignored while idle.
    for (int i = 0; i < 4; i++) applyStimulus(1'($urandom), 1'b0, 0, 1'b0);
    checkOutput("idle_discard_busy", {31'b0, busy}, 32'd0);

    foreach (vecs[i]) begin
      sendFrame(vecs[i].data, vecs[i].par, vecs[i].gap);
      expectFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_err);
`ifdef PARITY_RX_ERR_CNT_EN
      if (i == 1) checkOutput("err_cnt_after_bad_a5", {24'b0, err_cnt}, 32'd1);
`endif
    end

    runAbort("abort_data", 4, 8'hFF, 1'b1);
    runAbort("abort_parity", 7, 8'h3C, 1'b1);

    // Back-to-back frames with no idle cycle between them.
    sendFrame(8'h01, 1'b0, 0);
    sendFrame(8'h80, 1'b0, 0);
    getResult(r1, ok1);
    getResult(r2, ok2);
    if (ok1 && ok2) begin
      checkOutput("b2b_data0", {24'b0, r1.data}, 32'h01);
      checkOutput("b2b_err0", {31'b0, r1.err}, 32'd0);
      checkOutput("b2b_data1", {24'b0, r2.data}, 32'h80);
      checkOutput("b2b_err1", {31'b0, r2.err}, 32'd0);
      checkOutput("b2b_spacing", r2.cyc - r1.cyc, 32'd9);
    end
    last_data = 8'h80;
    last_err  = 1'b0;
    tick();

    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rg = int'($urandom_range(3, 0));
      sendFrame(rd, rp, rg);
      expectFrame("rand", rd, refErr(rd, rp));
    end

    checkOutput("frm_pulse_count", frm_pulses, exp_frm_pulses);
`ifdef PARITY_RX_ERR_CNT_EN
    checkOutput("err_cnt_total", {24'b0, err_cnt}, model_err);
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    checkOutput("err_cnt_clear", {24'b0, err_cnt}, 32'd0);
    model_err = 0;
`endif

    // Reset asserted while bit 5 of a frame is on the wire.
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    for (int i = 1; i < 5; i++) applyStimulus(1'($urandom), 1'b0, 0, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_data", {24'b0, out_data}, 32'd0);
    checkOutput("midrst_par_err", {31'b0, out_par_err}, 32'd0);
    checkOutput("midrst_frm_err", {31'b0, out_frm_err}, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    last_data = 8'h00;
    last_err  = 1'b0;
    model_err = 0;
    sendFrame(8'h5A, 1'b1, 0);
    expectFrame("post_rst", 8'h5A, 1'b0);
    checkOutput("no_extra_frm", frm_pulses, exp_frm_pulses);
    checkOutput("no_extra_valid", resq.size(), 32'd0);
`ifdef PARITY_RX_ERR_CNT_EN
    checkOutput("err_cnt_post_rst", {24'b0, err_cnt}, model_err);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
